// File: rtl/icache_loader.sv
// icache_loader: boot-time program loader.
// Consumes a little-endian byte stream (LEN_LO, LEN_HI, then N instructions
// as low/high byte pairs), writes each 16-bit instruction into the ICache and
// holds the core in reset until the image is complete.
// Optional feature macro: ICACHE_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and the sticky error flag.
module icache_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        write_enable,
  output logic [31:0] write_instruction_index,
  output logic [15:0] write_instruction,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_INS_LO = 3'd2,
    S_INS_HI = 3'd3,
`ifdef ICACHE_LOADER_CHECKSUM_EN
    S_CSUM   = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  // State entered after the last instruction (or an empty image).
`ifdef ICACHE_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_t      state_reg, state_next;
  logic [15:0] count_reg;
  logic [15:0] k_reg;
  logic [7:0]  lo_reg;
  logic        write_enable_reg;
  logic [31:0] index_reg;
  logic [15:0] instr_reg;
  logic        overflow_reg;
  logic        xfer;
  logic        last_ins;
  logic        k_in_range;

  assign byte_ready = (state_reg != S_DONE);
  assign xfer       = byte_valid && byte_ready;
  // 17-bit compare so that N=65535 terminates correctly.
  assign last_ins   = (({1'b0, k_reg} + 17'd1) == {1'b0, count_reg});
  assign k_in_range = ({16'd0, k_reg} < DEPTH_U);

  assign done                    = (state_reg == S_DONE);
  assign cpu_hold                = ~done;
  assign write_enable            = write_enable_reg;
  assign write_instruction_index = index_reg;
  assign write_instruction       = instr_reg;
  assign overflow                = overflow_reg;

  // Next-state logic: advance only on an accepted byte.
  always_comb begin
    state_next = state_reg;
    if (xfer) begin
      case (state_reg)
        S_LEN_LO: state_next = S_LEN_HI;
        S_LEN_HI: state_next = ({byte_data, count_reg[7:0]} == 16'd0) ? S_END : S_INS_LO;
        S_INS_LO: state_next = S_INS_HI;
        S_INS_HI: state_next = last_ins ? S_END : S_INS_LO;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        S_CSUM:   state_next = S_DONE;
`endif
        default:  state_next = state_reg;
      endcase
    end
  end

  // State register and datapath: latch length/low byte, issue one-cycle writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_LEN_LO;
      count_reg        <= 16'd0;
      k_reg            <= 16'd0;
      lo_reg           <= 8'd0;
      write_enable_reg <= 1'b0;
      index_reg        <= 32'd0;
      instr_reg        <= 16'd0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      write_enable_reg <= 1'b0;
      if (xfer) begin
        case (state_reg)
          S_LEN_LO: count_reg[7:0]  <= byte_data;
          S_LEN_HI: count_reg[15:8] <= byte_data;
          S_INS_LO: lo_reg          <= byte_data;
          S_INS_HI: begin
            instr_reg <= {byte_data, lo_reg};
            index_reg <= {16'd0, k_reg};
            k_reg     <= k_reg + 16'd1;
            if (k_in_range) write_enable_reg <= 1'b1;
            else            overflow_reg     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ICACHE_LOADER_CHECKSUM_EN
  logic [7:0] csum_reg;
  logic       error_reg;

  // Running XOR over length and instruction bytes; compare against the trailer.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_reg  <= 8'd0;
      error_reg <= 1'b0;
    end else if (xfer) begin
      if (state_reg == S_CSUM) begin
        if (byte_data != csum_reg) error_reg <= 1'b1;
      end else begin
        csum_reg <= csum_reg ^ byte_data;
      end
    end
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

endmodule
